// File: rtl/contador_autos.sv
// Parking-lot vehicle counter: synced/debounced optical sensors, direction FSM, saturating BCD count, muxed 7-seg.
// Define CONTADOR_BLANK_ZERO_EN to blank the tens digit while it is zero.
`timescale 1ns/1ps

module contador_autos_debounce #(
   parameter int COUNT = 1000000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic level
);
   localparam int W = (COUNT > 1) ? $clog2(COUNT) : 1;
   localparam logic [W-1:0] LOAD = W'(COUNT - 1);

   logic         meta;
   logic         synced;
   logic [W-1:0] cnt;

   // Down-counter reloads on every agreement, so only an unbroken mismatch run reaches zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta   <= 1'b0;
         synced <= 1'b0;
         level  <= 1'b0;
         cnt    <= LOAD;
      end else begin
         meta   <= raw;
         synced <= meta;
         if (synced == level) begin
            cnt <= LOAD;
         end else if (cnt == '0) begin
            level <= synced;
            cnt   <= LOAD;
         end else begin
            cnt <= cnt - 1'b1;
         end
      end
   end
endmodule

module contador_autos_bcd (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       inc,
   input  logic       dec,
   output logic [3:0] unidades,
   output logic [3:0] decenas
);
   logic at_max;
   logic at_min;

   assign at_max = (decenas == 4'd9) && (unidades == 4'd9);
   assign at_min = (decenas == 4'd0) && (unidades == 4'd0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         unidades <= 4'd0;
         decenas  <= 4'd0;
      end else if (inc && !at_max) begin
         if (unidades == 4'd9) begin
            unidades <= 4'd0;
            decenas  <= decenas + 4'd1;
         end else begin
            unidades <= unidades + 4'd1;
         end
      end else if (dec && !at_min) begin
         if (unidades == 4'd0) begin
            unidades <= 4'd9;
            decenas  <= decenas - 4'd1;
         end else begin
            unidades <= unidades - 4'd1;
         end
      end
   end
endmodule

module contador_autos #(
   parameter int DIV_COUNT      = 100000,
   parameter int DEBOUNCE_COUNT = 1000000
) (
   input  logic       clk,
   input  logic       reset_btn,
   input  logic       S1,
   input  logic       S2,
   output logic [6:0] seg,
   output logic [7:0] an
);
   // state    | meaning
   // IDLE     | lot entrance clear, waiting for a beam
   // IN1      | outer beam only: vehicle starting to enter
   // IN2      | both beams: entering vehicle straddles sensors
   // IN3      | inner beam only: entering vehicle nearly through
   // OUT1     | inner beam only: vehicle starting to exit
   // OUT2     | both beams: exiting vehicle straddles sensors
   // OUT3     | outer beam only: exiting vehicle nearly through
   // WAIT_CLR | illegal pattern seen, wait for both beams clear
   typedef enum logic [2:0] {
      IDLE, IN1, IN2, IN3, OUT1, OUT2, OUT3, WAIT_CLR
   } state_t;

   localparam int DIV_W = (DIV_COUNT > 1) ? $clog2(DIV_COUNT) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_COUNT - 1);

   logic             S1_debounced;
   logic             S2_debounced;
   logic [1:0]       p;
   state_t           state;
   state_t           state_next;
   logic             entered_next;
   logic             exited_next;
   logic             vehicle_entered;
   logic             vehicle_exited;
   logic [3:0]       unidades;
   logic [3:0]       decenas;
   logic [DIV_W-1:0] div;
   logic             sel;
   logic [6:0]       seg_next;
   logic [7:0]       an_next;

   contador_autos_debounce #(.COUNT(DEBOUNCE_COUNT)) s1_deb (
      .clk(clk), .rst_n(reset_btn), .raw(S1), .level(S1_debounced)
   );

   contador_autos_debounce #(.COUNT(DEBOUNCE_COUNT)) s2_deb (
      .clk(clk), .rst_n(reset_btn), .raw(S2), .level(S2_debounced)
   );

   assign p = {S1_debounced, S2_debounced};

   always_ff @(posedge clk or negedge reset_btn) begin
      if (!reset_btn) begin
         state           <= IDLE;
         vehicle_entered <= 1'b0;
         vehicle_exited  <= 1'b0;
      end else begin
         state           <= state_next;
         vehicle_entered <= entered_next;
         vehicle_exited  <= exited_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: case (p)
            2'b10:   state_next = IN1;
            2'b01:   state_next = OUT1;
            2'b11:   state_next = WAIT_CLR;
            default: state_next = IDLE;
         endcase
         IN1: case (p)
            2'b11:   state_next = IN2;
            2'b00:   state_next = IDLE;
            2'b01:   state_next = WAIT_CLR;
            default: state_next = IN1;
         endcase
         IN2: case (p)
            2'b01:   state_next = IN3;
            2'b10:   state_next = IN1;
            2'b00:   state_next = IDLE;
            default: state_next = IN2;
         endcase
         IN3: case (p)
            2'b00:   state_next = IDLE;
            2'b11:   state_next = IN2;
            2'b10:   state_next = WAIT_CLR;
            default: state_next = IN3;
         endcase
         OUT1: case (p)
            2'b11:   state_next = OUT2;
            2'b00:   state_next = IDLE;
            2'b10:   state_next = WAIT_CLR;
            default: state_next = OUT1;
         endcase
         OUT2: case (p)
            2'b10:   state_next = OUT3;
            2'b01:   state_next = OUT1;
            2'b00:   state_next = IDLE;
            default: state_next = OUT2;
         endcase
         OUT3: case (p)
            2'b00:   state_next = IDLE;
            2'b11:   state_next = OUT2;
            2'b01:   state_next = WAIT_CLR;
            default: state_next = OUT3;
         endcase
         WAIT_CLR: if (p == 2'b00) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Only the final clear after the last-beam state counts; the pulse is registered above.
   always_comb begin
      entered_next = (state == IN3)  && (p == 2'b00);
      exited_next  = (state == OUT3) && (p == 2'b00);
   end

   contador_autos_bcd counter_inst (
      .clk(clk), .rst_n(reset_btn),
      .inc(vehicle_entered), .dec(vehicle_exited),
      .unidades(unidades), .decenas(decenas)
   );

   always_ff @(posedge clk or negedge reset_btn) begin
      if (!reset_btn) begin
         div <= '0;
         sel <= 1'b0;
      end else if (div == DIV_LAST) begin
         div <= '0;
         sel <= ~sel;
      end else begin
         div <= div + 1'b1;
      end
   end

   function automatic logic [6:0] decode(input logic [3:0] d);
      case (d)
         4'd0:    decode = 7'b1000000;
         4'd1:    decode = 7'b1111001;
         4'd2:    decode = 7'b0100100;
         4'd3:    decode = 7'b0110000;
         4'd4:    decode = 7'b0011001;
         4'd5:    decode = 7'b0010010;
         4'd6:    decode = 7'b0000010;
         4'd7:    decode = 7'b1111000;
         4'd8:    decode = 7'b0000000;
         4'd9:    decode = 7'b0010000;
         default: decode = 7'h7F;
      endcase
   endfunction

   always_comb begin
      if (!sel) begin
         an_next  = 8'hFE;
         seg_next = decode(unidades);
      end else begin
         an_next  = 8'hFD;
         seg_next = decode(decenas);
`ifdef CONTADOR_BLANK_ZERO_EN
         if (decenas == 4'd0) begin
            an_next  = 8'hFF;
            seg_next = 7'h7F;
         end
`endif
      end
   end

   // Registered so the display is dark for the whole reset, not just until sel settles.
   always_ff @(posedge clk or negedge reset_btn) begin
      if (!reset_btn) begin
         seg <= 7'h7F;
         an  <= 8'hFF;
      end else begin
         seg <= seg_next;
         an  <= an_next;
      end
   end
endmodule

// File: tb/tb_contador_autos.sv
// Directed bench for contador_autos: entries, exits, back-outs, saturation, reset abort, glitch rejection.
`timescale 1ns/1ps

module tb_contador_autos;
   logic       clk = 1'b0;
   logic       reset_btn;
   logic       S1;
   logic       S2;
   logic [6:0] seg;
   logic [7:0] an;

   int errors = 0;
   int checks = 0;
   int ent_cnt = 0;
   int ex_cnt = 0;
   int both_cnt = 0;
   int dbl_cnt = 0;
   logic prev_e = 1'b0;
   logic prev_x = 1'b0;

   contador_autos #(.DIV_COUNT(100), .DEBOUNCE_COUNT(10)) dut (
      .clk(clk), .reset_btn(reset_btn), .S1(S1), .S2(S2), .seg(seg), .an(an)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (dut.vehicle_entered === 1'b1) ent_cnt++;
      if (dut.vehicle_exited === 1'b1) ex_cnt++;
      if (dut.vehicle_entered === 1'b1 && dut.vehicle_exited === 1'b1) both_cnt++;
      if ((dut.vehicle_entered === 1'b1 && prev_e) || (dut.vehicle_exited === 1'b1 && prev_x)) dbl_cnt++;
      prev_e = (dut.vehicle_entered === 1'b1);
      prev_x = (dut.vehicle_exited === 1'b1);
   end

   function automatic logic [6:0] pat(input int d);
      case (d)
         0: pat = 7'h40;
         1: pat = 7'h79;
         2: pat = 7'h24;
         3: pat = 7'h30;
         4: pat = 7'h19;
         5: pat = 7'h12;
         6: pat = 7'h02;
         7: pat = 7'h78;
         8: pat = 7'h00;
         9: pat = 7'h10;
         default: pat = 7'h7F;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic phase(input logic a, input logic b);
      S1 = a;
      S2 = b;
      #200;
   endtask

   task automatic entry();
      phase(1, 0); phase(1, 1); phase(0, 1); phase(0, 0);
   endtask

   task automatic exit_car();
      phase(0, 1); phase(1, 1); phase(1, 0); phase(0, 0);
   endtask

   task automatic wait_an(input logic [7:0] target, output logic ok);
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (an === target) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic check_count(input string tag, input int u, input int d);
      chk({tag, "_unidades"}, 32'(dut.unidades), 32'(u));
      chk({tag, "_decenas"}, 32'(dut.decenas), 32'(d));
   endtask

   task automatic check_display(input string tag, input int u, input int d);
      logic ok;
      wait_an(8'hFE, ok);
      chk({tag, "_an_units_seen"}, 32'(ok), 32'd1);
      chk({tag, "_seg_units"}, 32'(seg), 32'(pat(u)));
      wait_an(8'hFD, ok);
      chk({tag, "_an_tens_seen"}, 32'(ok), 32'd1);
      chk({tag, "_seg_tens"}, 32'(seg), 32'(pat(d)));
   endtask

   initial begin
      logic [7:0] a1;
      logic [7:0] a2;
      reset_btn = 1'b1;
      S1 = 1'b0;
      S2 = 1'b0;
      #2 reset_btn = 1'b0;
      #148;
      chk("reset_seg", 32'(seg), 32'h7F);
      chk("reset_an", 32'(an), 32'hFF);
      check_count("reset", 0, 0);
      #50 reset_btn = 1'b1;
      check_display("after_reset", 0, 0);

      for (int i = 0; i < 20; i++) entry();
      chk("entries20_pulses", 32'(ent_cnt), 32'd20);
      chk("entries20_exits", 32'(ex_cnt), 32'd0);
      check_count("entries20", 0, 2);
      check_display("entries20", 0, 2);

      for (int i = 0; i < 5; i++) exit_car();
      chk("exits5_pulses", 32'(ex_cnt), 32'd5);
      chk("exits5_entries", 32'(ent_cnt), 32'd20);
      check_count("exits5", 5, 1);
      check_display("exits5", 5, 1);

      phase(1, 0); phase(0, 0);
      phase(0, 1); phase(0, 0);
      phase(1, 0); phase(1, 1); phase(1, 0); phase(0, 0);
      chk("backout_entries", 32'(ent_cnt), 32'd20);
      chk("backout_exits", 32'(ex_cnt), 32'd5);
      check_count("backout", 5, 1);

      for (int i = 0; i < 84; i++) entry();
      check_count("reach99", 9, 9);
      check_display("reach99", 9, 9);
      entry();
      chk("sat99_pulses", 32'(ent_cnt), 32'd105);
      check_count("sat99", 9, 9);
      exit_car();
      chk("exit98_pulses", 32'(ex_cnt), 32'd6);
      check_count("exit98", 8, 9);

      phase(1, 0);
      S2 = 1'b1;
      #100 reset_btn = 1'b0;
      #50;
      chk("midreset_seg", 32'(seg), 32'h7F);
      chk("midreset_an", 32'(an), 32'hFF);
      check_count("midreset", 0, 0);
      S1 = 1'b0;
      S2 = 1'b0;
      #50 reset_btn = 1'b1;
      #200;
      chk("midreset_entries", 32'(ent_cnt), 32'd105);
      chk("midreset_exits", 32'(ex_cnt), 32'd6);
      check_count("after_midreset", 0, 0);

      #3 S1 = 1'b1; #5 S1 = 1'b0;
      #31 S2 = 1'b1; #5 S2 = 1'b0;
      #27 S1 = 1'b1; #5 S1 = 1'b0; S2 = 1'b1; #5 S2 = 1'b0;
      #40 S1 = 1'b1; S2 = 1'b1; #20 S1 = 1'b0; S2 = 1'b0;
      #200;
      chk("glitch_s1_deb", 32'(dut.S1_debounced), 32'd0);
      chk("glitch_s2_deb", 32'(dut.S2_debounced), 32'd0);
      chk("glitch_entries", 32'(ent_cnt), 32'd105);
      chk("glitch_exits", 32'(ex_cnt), 32'd6);
      check_count("glitch", 0, 0);

      @(negedge clk);
      a1 = an;
      chk("an_valid", 32'((a1 === 8'hFE) || (a1 === 8'hFD)), 32'd1);
      repeat (100) @(negedge clk);
      a2 = an;
      chk("an_toggle_100", 32'(a2), (a1 === 8'hFE) ? 32'hFD : 32'hFE);
      repeat (100) @(negedge clk);
      chk("an_toggle_200", 32'(an), 32'(a1));

      chk("pulse_exclusive", 32'(both_cnt), 32'd0);
      chk("pulse_single_cycle", 32'(dbl_cnt), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
